temp_link_rx: RTL and testbench

Receives LM35 temperature readings from the ESP32 over the 3-bit parallel link (`db[2:0]` plus `ack` strobe) and presents them as a clean 6-bit value to the seven-segment display stage.
- The block synchronises and deglitches the asynchronous pins.
- It assembles two 3-bit chunks, MSB chunk first, into one reading and issues a one-cycle valid pulse.
- It discards incomplete frames after a timeout and flags a stale link when readings stop arriving.

---
 rtl/temp_link_rx_if.sv | 11 +
 rtl/temp_link_rx.sv | 76 +++++++
 tb/tb_temp_link_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/temp_link_rx_if.sv
// temp_link_rx_if: ESP32 link pins (ack, db) toward the receiver and its outputs (temp, temp_valid, frame_err, stale)
interface temp_link_rx_if;
  logic ack;
  logic [2:0] db;
  logic [5:0] temp;
  logic temp_valid;
  logic frame_err;
  logic stale;
  modport master (output ack, db, input temp, temp_valid, frame_err, stale);
  modport slave (input ack, db, output temp, temp_valid, frame_err, stale);
endinterface

// File: rtl/temp_link_rx.sv
// temp_link_rx: synchronise/deglitch ESP32 3-bit link and assemble two chunks into 6-bit temp (clk, rst, link.slave: ack/db in; temp/temp_valid/frame_err/stale out)
module temp_link_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int STALE_CYCLES = 50_000_000
) (
  input logic clk,
  input logic rst,
  temp_link_rx_if.slave link
);
  localparam int FW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam logic [FW-1:0] F_MAX = FW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] S_MAX = SW'(STALE_CYCLES);
  typedef enum logic {IDLE, WAIT_LO} state_t;
  state_t state, state_nx;
  logic ack_s1, ack_sync, ack_filt, ack_filt_d;
  logic [2:0] db_s1, db_sync, chunk, hi;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic flip, strobe, timeout, load_hi, valid_nx, err_nx;
  assign flip = ack_sync != ack_filt && fcnt == F_MAX;
  assign strobe = ack_filt & ~ack_filt_d;
  assign timeout = tcnt == T_MAX;
  assign link.stale = scnt == S_MAX;
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_sync <= 1'b0;
      db_s1 <= '0;
      db_sync <= '0;
      ack_filt <= 1'b0;
      ack_filt_d <= 1'b0;
      fcnt <= '0;
      chunk <= '0;
    end else begin
      ack_s1 <= link.ack;
      ack_sync <= ack_s1;
      db_s1 <= link.db;
      db_sync <= db_s1;
      ack_filt_d <= ack_filt;
      fcnt <= (ack_sync == ack_filt || flip) ? '0 : fcnt + 1'b1;
      if (flip) ack_filt <= ack_sync;
      if (flip && ack_sync) chunk <= db_sync;
    end
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = strobe ? (state == IDLE ? WAIT_LO : IDLE) : (state == WAIT_LO && timeout ? IDLE : state);
  always_comb begin
    load_hi = state == IDLE && strobe;
    valid_nx = state == WAIT_LO && strobe;
    err_nx = state == WAIT_LO && !strobe && timeout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      tcnt <= '0;
      scnt <= S_MAX;
      link.temp <= '0;
      link.temp_valid <= 1'b0;
      link.frame_err <= 1'b0;
    end else begin
      if (load_hi) hi <= chunk;
      tcnt <= load_hi ? '0 : state == WAIT_LO ? tcnt + 1'b1 : tcnt;
      scnt <= link.temp_valid ? '0 : scnt == S_MAX ? scnt : scnt + 1'b1;
      if (valid_nx) link.temp <= {hi, chunk};
      link.temp_valid <= valid_nx;
      link.frame_err <= err_nx;
    end
  end
endmodule

// File: tb/tb_temp_link_rx.sv
// tb_temp_link_rx: random and directed link traffic checked against an event-level model of temp_link_rx
module tb_temp_link_rx;
  localparam int S = 4, T = 100, ST = 50;
  logic clk = 1'b0, rst = 1'b1;
  temp_link_rx_if link();
  temp_link_rx #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .STALE_CYCLES(ST)) dut (.clk(clk), .rst(rst), .link(link.slave));
  always #5 clk = ~clk;
  typedef struct {int t; logic [2:0] d;} ev_t;
  ev_t evq[$];
  ev_t e;
  int total = 0, bad = 0, cyc = 0;
  bit armed = 0, prev = 0, wait_lo = 0;
  int run = 0, start = 0, entered = 0, last_c = -1;
  int n_valid = 0, n_err = 0, last_valid = 0, last_rise = 0;
  logic [2:0] dval, hi;
  logic [5:0] m_temp = '0;
  logic m_valid = 1'b0, m_err = 1'b0, m_stale = 1'b1;
  // A high run of at least S samples starting at edge N is a chunk that reaches the FSM at edge N+S+2.
  always @(posedge clk) begin
    cyc++;
    m_stale = last_c < 0 || cyc - last_c - 1 >= ST;
    m_valid = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      armed = 1;
      evq.delete();
      wait_lo = 0;
      prev = 0;
      run = 0;
      last_c = -1;
      m_temp = '0;
      m_stale = 1'b1;
    end else begin
      if (link.ack) begin
        if (!prev) begin
          start = cyc;
          dval = link.db;
          run = 0;
        end
        run++;
        if (run == S) evq.push_back('{start + S + 2, dval});
      end
      prev = link.ack;
      if (evq.size() > 0 && evq[0].t == cyc) begin
        e = evq.pop_front();
        if (wait_lo) begin
          m_temp = {hi, e.d};
          m_valid = 1'b1;
          last_c = cyc;
          wait_lo = 0;
        end else begin
          hi = e.d;
          wait_lo = 1;
          entered = cyc;
        end
      end else if (wait_lo && cyc == entered + T) begin
        m_err = 1'b1;
        wait_lo = 0;
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0d expected=%0d", n, cyc, a, x);
    end
  endtask
  always @(negedge clk)
    if (armed) begin
      chk("temp", 32'(link.temp), 32'(m_temp));
      chk("temp_valid", 32'(link.temp_valid), 32'(m_valid));
      chk("frame_err", 32'(link.frame_err), 32'(m_err));
      chk("stale", 32'(link.stale), 32'(m_stale));
      if (link.temp_valid === 1'b1) begin
        n_valid++;
        last_valid = cyc;
      end
      if (link.frame_err === 1'b1) n_err++;
    end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chunk(input logic [2:0] d, input int h, input int lo);
    link.db = d;
    idle(2);
    link.ack = 1'b1;
    last_rise = cyc + 1;
    idle(h);
    link.ack = 1'b0;
    idle(lo);
  endtask
  task automatic frame(input logic [2:0] a, input logic [2:0] b);
    chunk(a, 10, 10);
    chunk(b, 10, 10);
  endtask
  int v0, e0;
  initial begin
    link.ack = 1'b0;
    link.db = '0;
    idle(3);
    rst = 1'b0;
    #1;
    chk("reset temp", 32'(link.temp), 0);
    chk("reset valid", 32'(link.temp_valid), 0);
    chk("reset err", 32'(link.frame_err), 0);
    chk("reset stale", 32'(link.stale), 1);
    v0 = n_valid;
    frame(3'd3, 3'd1);
    #1;
    chk("basic temp", 32'(link.temp), 25);
    chk("basic pulses", n_valid, v0 + 1);
    chk("basic latency", last_valid - last_rise, S + 2);
    chk("basic stale", 32'(link.stale), 0);
    frame(3'd0, 3'd0);
    #1;
    chk("min temp", 32'(link.temp), 0);
    frame(3'd7, 3'd7);
    #1;
    chk("max temp", 32'(link.temp), 63);
    chk("no err", n_err, 0);
    chunk(3'd2, 10, 10);
    chunk(3'd5, 3, 10);
    chunk(3'd4, 10, 10);
    #1;
    chk("glitch temp", 32'(link.temp), 20);
    e0 = n_err;
    chunk(3'd6, 10, 10);
    idle(200);
    #1;
    chk("timeout err", n_err, e0 + 1);
    chk("timeout hold", 32'(link.temp), 20);
    frame(3'd1, 3'd2);
    #1;
    chk("after timeout", 32'(link.temp), 10);
    chunk(3'd3, 10, 88);
    chunk(3'd5, 10, 10);
    #1;
    chk("collision temp", 32'(link.temp), 29);
    chk("collision err", n_err, e0 + 1);
    chunk(3'd6, 10, 10);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    #1;
    chk("midreset temp", 32'(link.temp), 0);
    chk("midreset stale", 32'(link.stale), 1);
    frame(3'd1, 3'd1);
    while (cyc < last_valid + ST) @(negedge clk);
    #1;
    chk("stale edge-1", 32'(link.stale), 0);
    @(negedge clk);
    #1;
    chk("stale edge", 32'(link.stale), 1);
    link.db = 3'd5;
    idle(2);
    link.ack = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    link.ack = 1'b0;
    idle(10);
    chunk(3'd2, 10, 10);
    #1;
    chk("held ack after reset", 32'(link.temp), 42);
    for (int i = 0; i < 250; i++)
      chunk(3'($urandom_range(0, 7)), $urandom_range(1, 12),
            $urandom_range(0, 7) == 0 ? $urandom_range(90, 110) : $urandom_range(S, 12));
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
